// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_monitor
//  Purpose  : Safety monitor on the controller's four light buses. Every clock
//             it checks encoding, cross-approach conflicts, per-light sequence
//             order, minimum yellow time and all-red stall. The first
//             violation is latched into a sticky fault report.
//  Ports    : clk             - system clock, rising edge
//             rst             - asynchronous reset, active low
//             light_M1/M2/MT/S- 3-bit light codes {red, yellow, green}
//             clr_fault       - synchronous clear of the fault report
//             fault           - sticky fault flag
//             fault_code      - code of the first latched violation
//             fault_light     - lights involved {M1, M2, MT, S}
//             violation_count - violating cycles, saturating at 255
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
  parameter int MIN_YELLOW  = 3,
  parameter int MAX_ALL_RED = 5,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] fault_light,
  output logic [7:0] violation_count
);

  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_GRN = 3'b001;

  localparam logic [2:0] C_CODE_ENC   = 3'd1;
  localparam logic [2:0] C_CODE_CONF  = 3'd2;
  localparam logic [2:0] C_CODE_SEQ   = 3'd3;
  localparam logic [2:0] C_CODE_SHORT = 3'd4;
  localparam logic [2:0] C_CODE_STALL = 3'd5;

  localparam logic [CNT_W-1:0] C_MIN_YEL = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] C_MAX_RED = CNT_W'(MAX_ALL_RED);

  // Index 3 = M1, 2 = M2, 1 = MT, 0 = S, matching fault_light bit order.
  logic [3:0][2:0]       cur;
  logic [3:0][2:0]       prev;
  logic [3:0][CNT_W-1:0] ycnt;
  logic [CNT_W-1:0]      red_cnt;
  logic                  primed;

  logic [3:0] valid;
  logic [3:0] not_red;
  logic [3:0] is_red;
  logic [3:0] enc_err;
  logic [3:0] seq_err;
  logic [3:0] short_err;
  logic [3:0] conf_light;
  logic       all_red;
  logic       stall;
  logic       any_viol;
  logic [2:0] win_code;
  logic [3:0] win_light;

  assign cur = {light_M1, light_M2, light_MT, light_S};

  always_comb begin
    valid      = '0;
    not_red    = '0;
    is_red     = '0;
    enc_err    = '0;
    seq_err    = '0;
    short_err  = '0;
    conf_light = '0;
    win_code   = '0;
    win_light  = '0;

    for (int i = 0; i < 4; i++) begin
      valid[i]   = (cur[i] == C_RED) || (cur[i] == C_YEL) || (cur[i] == C_GRN);
      enc_err[i] = !valid[i];
      is_red[i]  = (cur[i] == C_RED);
      not_red[i] = valid[i] && !is_red[i];
      // prev only ever holds legal codes, so no validity check on it.
      seq_err[i] = primed && valid[i] &&
                   (((prev[i] == C_RED) && (cur[i] == C_YEL)) ||
                    ((prev[i] == C_GRN) && (cur[i] == C_RED)) ||
                    ((prev[i] == C_YEL) && (cur[i] == C_GRN)));
      short_err[i] = primed && (prev[i] == C_YEL) && is_red[i] &&
                     (ycnt[i] < C_MIN_YEL);
    end

    // Side road against any main light, then turn against opposing main.
    if (not_red[0] && (|not_red[3:1]))
      conf_light = conf_light | {not_red[3:1], 1'b1};
    if (not_red[1] && not_red[2])
      conf_light = conf_light | 4'b0110;

    all_red = &is_red;
    // Fires only on the sample that pushes the run past the limit; the
    // saturation guard keeps it from re-firing while the counter is pinned.
    stall   = all_red && (red_cnt == C_MAX_RED) && (red_cnt != '1);

    // Lowest code wins.
    if (|enc_err) begin
      win_code  = C_CODE_ENC;
      win_light = enc_err;
    end else if (|conf_light) begin
      win_code  = C_CODE_CONF;
      win_light = conf_light;
    end else if (|seq_err) begin
      win_code  = C_CODE_SEQ;
      win_light = seq_err;
    end else if (|short_err) begin
      win_code  = C_CODE_SHORT;
      win_light = short_err;
    end else if (stall) begin
      win_code  = C_CODE_STALL;
      win_light = 4'b1111;
    end

    any_viol = (win_code != 3'd0);
  end

  // History, run counters and prime flag are unaffected by clr_fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      primed  <= 1'b0;
      red_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        prev[i] <= C_RED;
        ycnt[i] <= '0;
      end
    end else begin
      primed  <= 1'b1;
      red_cnt <= all_red ? ((red_cnt == '1) ? red_cnt : red_cnt + 1'b1) : '0;
      for (int i = 0; i < 4; i++) begin
        if (valid[i])
          prev[i] <= cur[i];
        if (cur[i] == C_YEL)
          ycnt[i] <= (ycnt[i] == '1) ? ycnt[i] : ycnt[i] + 1'b1;
        else
          ycnt[i] <= '0;
      end
    end
  end

  // Fault report. A clear in the same cycle as a violation clears first and
  // then latches the new violation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault           <= 1'b0;
      fault_code      <= '0;
      fault_light     <= '0;
      violation_count <= '0;
    end else if (clr_fault) begin
      fault           <= any_viol;
      fault_code      <= win_code;
      fault_light     <= win_light;
      violation_count <= any_viol ? 8'd1 : 8'd0;
    end else begin
      if (any_viol && !fault) begin
        fault       <= 1'b1;
        fault_code  <= win_code;
        fault_light <= win_light;
      end
      if (any_viol && (violation_count != 8'hFF))
        violation_count <= violation_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_monitor
//  Purpose  : Directed-vector bench for traffic_light_monitor. Each driven
//             cycle pushes its hand-computed expected report into a queue;
//             a monitor pops and compares after every rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] light_M1 = R;
  logic [2:0] light_M2 = R;
  logic [2:0] light_MT = R;
  logic [2:0] light_S  = R;
  logic       clr_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] fault_light;
  logic [7:0] violation_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic       f;
    logic [2:0] c;
    logic [3:0] l;
    logic [7:0] n;
  } exp_t;

  exp_t exp_q[$];

  traffic_light_monitor #(
    .MIN_YELLOW (3),
    .MAX_ALL_RED(5),
    .CNT_W      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .light_M1       (light_M1),
    .light_M2       (light_M2),
    .light_MT       (light_MT),
    .light_S        (light_S),
    .clr_fault      (clr_fault),
    .fault          (fault),
    .fault_code     (fault_code),
    .fault_light    (fault_light),
    .violation_count(violation_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".fault"}, {7'd0, fault}, {7'd0, e.f});
      check({e.tag, ".code"},  {5'd0, fault_code}, {5'd0, e.c});
      check({e.tag, ".light"}, {4'd0, fault_light}, {4'd0, e.l});
      check({e.tag, ".count"}, violation_count, e.n);
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string tag, input logic [2:0] m1, input logic [2:0] m2,
                      input logic [2:0] mt, input logic [2:0] s, input logic clr,
                      input logic ef, input logic [2:0] ec, input logic [3:0] el,
                      input logic [7:0] en);
    exp_t e;
    light_M1  = m1;
    light_M2  = m2;
    light_MT  = mt;
    light_S   = s;
    clr_fault = clr;
    e.tag = tag; e.f = ef; e.c = ec; e.l = el; e.n = en;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check({tag, ".rst_fault"}, {7'd0, fault}, 8'd0);
    check({tag, ".rst_code"},  {5'd0, fault_code}, 8'd0);
    check({tag, ".rst_light"}, {4'd0, fault_light}, 8'd0);
    check({tag, ".rst_count"}, violation_count, 8'd0);
    light_M1 = R; light_M2 = R; light_MT = R; light_S = R; clr_fault = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset("init");

    // Full legal cycle: no violation anywhere.
    for (int i = 0; i < 10; i++) step("legal_mg", G, G, R, R, 0, 0, 3'd0, 4'h0, 8'd0);
    for (int i = 0; i < 3; i++)  step("legal_my", Y, Y, R, R, 0, 0, 3'd0, 4'h0, 8'd0);
    for (int i = 0; i < 2; i++)  step("legal_ar", R, R, R, R, 0, 0, 3'd0, 4'h0, 8'd0);
    for (int i = 0; i < 8; i++)  step("legal_sg", R, R, R, G, 0, 0, 3'd0, 4'h0, 8'd0);
    for (int i = 0; i < 3; i++)  step("legal_sy", R, R, R, Y, 0, 0, 3'd0, 4'h0, 8'd0);
    for (int i = 0; i < 2; i++)  step("legal_sr", R, R, R, R, 0, 0, 3'd0, 4'h0, 8'd0);

    // S green with M1 green: conflict; clear with concurrent G->R sequence errors.
    do_reset("conf");
    step("conf_1",   G, R, R, G, 0, 1, 3'd2, 4'b1001, 8'd1);
    step("conf_2",   G, R, R, G, 0, 1, 3'd2, 4'b1001, 8'd2);
    step("conf_clr", R, R, R, R, 1, 1, 3'd3, 4'b1001, 8'd1);

    // M2 green to red after priming.
    do_reset("seq");
    step("seq_prime", G, G, R, R, 0, 0, 3'd0, 4'h0, 8'd0);
    step("seq_gr",    G, R, R, R, 0, 1, 3'd3, 4'b0100, 8'd1);

    // MT yellow only two cycles; first sample is unprimed so R->Y is excused.
    do_reset("short");
    step("short_y1", R, R, Y, R, 0, 0, 3'd0, 4'h0, 8'd0);
    step("short_y2", R, R, Y, R, 0, 0, 3'd0, 4'h0, 8'd0);
    step("short_r",  R, R, R, R, 0, 1, 3'd4, 4'b0010, 8'd1);

    // All red: five legal samples, sixth stalls, later ones do not re-count.
    do_reset("stall");
    for (int i = 0; i < 5; i++) step("stall_ok", R, R, R, R, 0, 0, 3'd0, 4'h0, 8'd0);
    step("stall_6", R, R, R, R, 0, 1, 3'd5, 4'b1111, 8'd1);
    for (int i = 0; i < 3; i++) step("stall_hold", R, R, R, R, 0, 1, 3'd5, 4'b1111, 8'd1);

    // Encoding beats conflict; then clear with a concurrent S/M2 conflict.
    do_reset("multi");
    step("multi_prime", R, R, R, R, 0, 0, 3'd0, 4'h0, 8'd0);
    step("multi_enc",   3'b011, G, R, G, 0, 1, 3'd1, 4'b1000, 8'd1);
    step("multi_clr",   R, G, R, G, 1, 1, 3'd2, 4'b0101, 8'd1);
    step("multi_after", R, G, R, G, 0, 1, 3'd2, 4'b0101, 8'd2);

    // Mid-operation reset with a fault latched.
    do_reset("midrst");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
